// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the data-memory initiator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_if_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   // IDLE must encode as zero so the reset state is the all-zero vector
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   // Mask covering the low 8*2^size bits
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      logic [63:0] m;
      case (size)
         SIZE_B:  m = 64'h0000_0000_0000_00FF;
         SIZE_H:  m = 64'h0000_0000_0000_FFFF;
         SIZE_W:  m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

   // True when the address is not a multiple of the access size in bytes
   function automatic logic misaligned(input logic [63:0] addr, input logic [1:0] size);
      logic [63:0] low_mask;
      low_mask = (64'd1 << size) - 64'd1;
      return (addr & low_mask) != 64'd0;
   endfunction

endpackage

// File: rtl/load_data_extend.sv
// Sign/zero extension of right-justified load data to 64 bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_data_extend
   import mem_if_pkg::*;
(
   input  logic [63:0] data_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [63:0] result_o
);

   logic [63:0] mask;
   logic        top_bit;

   // Mask to the access width, then fill the upper bits with the field's sign when asked
   always_comb begin
      mask = size_mask(size_i);
      case (size_i)
         SIZE_B:  top_bit = data_i[7];
         SIZE_H:  top_bit = data_i[15];
         SIZE_W:  top_bit = data_i[31];
         default: top_bit = 1'b0;
      endcase
      result_o = data_i & mask;
      if (signed_i && top_bit) begin
         result_o = result_o | ~mask;
      end
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator onto the dRead/dWrite memory channels.
// Latency: load >= 3 cycles, store >= 2 cycles, misaligned 1 cycle from accept to resp_valid.
// Backpressure: req_ready only in IDLE; waits indefinitely on addr/store ready and resp_ready, read data times out.
module lsu_mem_initiator
   import mem_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TAG_W          = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_store,
   input  logic [63:0]      req_address,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [63:0]      req_data,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_data,
   output logic             resp_err,
   output logic [TAG_W-1:0] resp_tag,
   output logic             mem_dRead_addressInfo_valid,
   input  logic             mem_dRead_addressInfo_ready,
   output logic [63:0]      mem_dRead_addressInfo_bits_address,
   output logic [1:0]       mem_dRead_addressInfo_bits_size,
   input  logic             mem_dRead_data_valid,
   output logic             mem_dRead_data_ready,
   input  logic [63:0]      mem_dRead_data_bits,
   output logic             mem_dWrite_storeInfo_valid,
   input  logic             mem_dWrite_storeInfo_ready,
   output logic [63:0]      mem_dWrite_storeInfo_bits_addressInfo_address,
   output logic [1:0]       mem_dWrite_storeInfo_bits_addressInfo_size,
   output logic [63:0]      mem_dWrite_storeInfo_bits_data
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q;
   logic [63:0]      addr_q;
   logic [1:0]       size_q;
   logic             signed_q;
   logic [63:0]      wdata_q;
   logic [TAG_W-1:0] tag_q;
   logic [63:0]      rdata_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [63:0]      ext_data;

   load_data_extend u_load_data_extend (
      .data_i   (mem_dRead_data_bits),
      .size_i   (size_q),
      .signed_i (signed_q),
      .result_o (ext_data)
   );

   // Read-wait cycle counter advance
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   // Request FSM; store data is masked at accept so the write channel never sees stray upper bits
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         wdata_q  <= '0;
         tag_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_address;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  wdata_q  <= req_data & size_mask(req_size);
                  tag_q    <= req_tag;
                  rdata_q  <= '0;
                  err_q    <= 1'b0;
                  if (misaligned(req_address, req_size)) begin
                     err_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end else if (req_is_store) begin
                     state_q <= ST_WR_REQ;
                  end else begin
                     state_q <= ST_RD_ADDR;
                  end
               end
            end
            ST_RD_ADDR: begin
               if (mem_dRead_addressInfo_ready) begin
                  cnt_q   <= '0;
                  state_q <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               // Data arriving on the timeout cycle takes priority over the error
               if (mem_dRead_data_valid) begin
                  rdata_q <= ext_data;
                  err_q   <= 1'b0;
                  state_q <= ST_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_WR_REQ: begin
               if (mem_dWrite_storeInfo_ready) begin
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready                                    = (state_q == ST_IDLE) && !reset;
   assign resp_valid                                   = (state_q == ST_RESP);
   assign resp_data                                    = rdata_q;
   assign resp_err                                     = err_q;
   assign resp_tag                                     = tag_q;
   assign mem_dRead_addressInfo_valid                  = (state_q == ST_RD_ADDR);
   assign mem_dRead_addressInfo_bits_address           = addr_q;
   assign mem_dRead_addressInfo_bits_size              = size_q;
   assign mem_dRead_data_ready                         = (state_q == ST_RD_WAIT);
   assign mem_dWrite_storeInfo_valid                   = (state_q == ST_WR_REQ);
   assign mem_dWrite_storeInfo_bits_addressInfo_address = addr_q;
   assign mem_dWrite_storeInfo_bits_addressInfo_size    = size_q;
   assign mem_dWrite_storeInfo_bits_data               = wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator against a transaction-level reference model.
// Latency: checks exact accept-to-response cycle counts.
// Backpressure: drives random address/store/response ready delays and late read data.
module tb_lsu_mem_initiator;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_is_store, req_signed;
   logic [63:0] req_address, req_data;
   logic [1:0]  req_size;
   logic [3:0]  req_tag;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_data;
   logic [3:0]  resp_tag;
   logic        rd_a_vld, rd_a_rdy;
   logic [63:0] rd_a_addr;
   logic [1:0]  rd_a_size;
   logic        rd_d_vld, rd_d_rdy;
   logic [63:0] rd_d_bits;
   logic        wr_vld, wr_rdy;
   logic [63:0] wr_addr, wr_dat;
   logic [1:0]  wr_size;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.TIMEOUT_CYCLES(TO), .TAG_W(4)) dut (
      .clk                                          (clk),
      .reset                                        (reset),
      .req_valid                                    (req_valid),
      .req_ready                                    (req_ready),
      .req_is_store                                 (req_is_store),
      .req_address                                  (req_address),
      .req_size                                     (req_size),
      .req_signed                                   (req_signed),
      .req_data                                     (req_data),
      .req_tag                                      (req_tag),
      .resp_valid                                   (resp_valid),
      .resp_ready                                   (resp_ready),
      .resp_data                                    (resp_data),
      .resp_err                                     (resp_err),
      .resp_tag                                     (resp_tag),
      .mem_dRead_addressInfo_valid                  (rd_a_vld),
      .mem_dRead_addressInfo_ready                  (rd_a_rdy),
      .mem_dRead_addressInfo_bits_address           (rd_a_addr),
      .mem_dRead_addressInfo_bits_size              (rd_a_size),
      .mem_dRead_data_valid                         (rd_d_vld),
      .mem_dRead_data_ready                         (rd_d_rdy),
      .mem_dRead_data_bits                          (rd_d_bits),
      .mem_dWrite_storeInfo_valid                   (wr_vld),
      .mem_dWrite_storeInfo_ready                   (wr_rdy),
      .mem_dWrite_storeInfo_bits_addressInfo_address (wr_addr),
      .mem_dWrite_storeInfo_bits_addressInfo_size    (wr_size),
      .mem_dWrite_storeInfo_bits_data               (wr_dat)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
   endtask

   // Reference extension: keep the low 8*2^sz bits, then arithmetic or logical shift back
   function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] sz, input logic sg);
      int          bits;
      logic [63:0] v;
      bits = 8 << sz;
      if (bits == 64) return d;
      v = d << (64 - bits);
      if (sg) return $signed(v) >>> (64 - bits);
      return v >> (64 - bits);
   endfunction

   task automatic idle_inputs();
      req_valid = 0; req_is_store = 0; req_address = '0; req_size = '0;
      req_signed = 0; req_data = '0; req_tag = '0; resp_ready = 0;
      rd_a_rdy = 0; rd_d_vld = 0; rd_d_bits = '0; wr_rdy = 0;
   endtask

   // One full transaction; d_dly >= TO means read data comes too late (or never)
   task automatic run_req(input logic st, input logic [63:0] addr, input logic [1:0] sz,
                          input logic sg, input logic [63:0] wd, input logic [3:0] tg,
                          input logic [63:0] md, input int a_dly, input int d_dly, input int r_dly);
      logic        mis, e_err;
      logic [63:0] e_data;
      int          e_lat, cyc, a_wait, r_wait, rw_start;
      bit          addr_done, resp_seen, done, rd_seen, wr_seen;
      mis = (addr % (64'd1 << sz)) != 64'd0;
      if (mis)            begin e_err = 1; e_data = '0; e_lat = 1; end
      else if (st)        begin e_err = 0; e_data = '0; e_lat = 2 + a_dly; end
      else if (d_dly < TO) begin e_err = 0; e_data = ref_ext(md, sz, sg); e_lat = 3 + a_dly + d_dly; end
      else                begin e_err = 1; e_data = '0; e_lat = 2 + a_dly + TO; end
      cyc = 0; a_wait = 0; r_wait = 0; rw_start = 0;
      addr_done = 0; resp_seen = 0; done = 0; rd_seen = 0; wr_seen = 0;

      chk("req_ready_idle", req_ready, 1);
      req_valid = 1; req_is_store = st; req_address = addr; req_size = sz;
      req_signed = sg; req_data = wd; req_tag = tg; rd_d_bits = md;
      @(posedge clk);
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         req_valid = 0; rd_a_rdy = 0; rd_d_vld = 0; wr_rdy = 0; resp_ready = 0;
         chk("rd_data_ready", rd_d_rdy, (addr_done && cyc >= rw_start && !resp_valid) ? 1 : 0);
         if (resp_valid) begin
            if (!resp_seen) begin
               resp_seen = 1;
               chk("resp_latency", 64'(cyc), 64'(e_lat));
               chk("resp_tag", resp_tag, tg);
            end
            chk("resp_data", resp_data, e_data);
            chk("resp_err", resp_err, e_err);
            if (r_wait == r_dly) begin resp_ready = 1; done = 1; end
            else r_wait++;
         end
         if (rd_a_vld) begin
            if (!rd_seen) begin
               chk("rd_addr", rd_a_addr, addr);
               chk("rd_size", rd_a_size, sz);
            end
            rd_seen = 1;
            if (a_wait == a_dly) begin rd_a_rdy = 1; addr_done = 1; rw_start = cyc + 1; end
            a_wait++;
         end
         if (addr_done && cyc >= rw_start && (cyc - rw_start) == d_dly) rd_d_vld = 1;
         if (wr_vld) begin
            if (!wr_seen) begin
               chk("wr_addr", wr_addr, addr);
               chk("wr_size", wr_size, sz);
               chk("wr_data", wr_dat, ref_ext(wd, sz, 1'b0));
            end
            wr_seen = 1;
            if (a_wait == a_dly) wr_rdy = 1;
            a_wait++;
         end
      end
      if (!done) chk("resp_never_seen", 0, 1);
      chk("rd_issued", rd_seen, (!st && !mis) ? 1 : 0);
      chk("wr_issued", wr_seen, (st && !mis) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      logic [63:0] md, a;
      logic [1:0]  sz;
      reset = 1;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rd_valid", rd_a_vld, 0);
      chk("rst_wr_valid", wr_vld, 0);
      chk("rst_rd_ready", rd_d_rdy, 0);
      chk("rst_rd_addr", rd_a_addr, 0);
      chk("rst_wr_data", wr_dat, 0);
      reset = 0;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);

      // Signed byte load of 0xF0
      md = {$urandom, $urandom}; md[7:0] = 8'hF0;
      run_req(0, 64'h1003, 2'd0, 1, 64'h0, 4'h5, md, 0, 0, 0);
      // Unsigned word load with the word's top bit set
      run_req(0, 64'h1000, 2'd2, 0, 64'h0, 4'h6, 64'hDEAD_BEEF_8000_0001, 1, 2, 1);
      // Half store with stray upper data
      run_req(1, 64'h2002, 2'd1, 0, 64'h1234_5678, 4'h7, 64'h0, 0, 0, 0);
      // Misaligned double load
      run_req(0, 64'h1004, 2'd3, 0, 64'h0, 4'h8, 64'h0, 0, 0, 0);
      // Timeout with data arriving one cycle late, during the response
      run_req(0, 64'h1008, 2'd3, 0, 64'h0, 4'h9, 64'h0123_4567_89AB_CDEF, 0, TO, 2);
      // Data on the same cycle the timeout would fire
      run_req(0, 64'h1010, 2'd3, 1, 64'h0, 4'hA, 64'hFEDC_BA98_7654_3210, 0, TO - 1, 0);
      // Memory never answers
      run_req(0, 64'h1018, 2'd1, 1, 64'h0, 4'hB, 64'h8000, 2, 1000, 0);

      // Reset while stalled in the read-address phase
      req_valid = 1; req_is_store = 0; req_address = 64'h3000; req_size = 2'd2; req_tag = 4'hC;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      repeat (5) begin
         chk("stall_rd_valid", rd_a_vld, 1);
         @(negedge clk);
      end
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_rd_valid", rd_a_vld, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_wr_valid", wr_vld, 0);
      chk("midrst_rd_ready", rd_d_rdy, 0);
      reset = 0;
      @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         run_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: bench did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Synthesizable initiator for the core's data-memory interface (the dRead and dWrite channels). It turns one load/store request at a time from the load/store pipeline into the matching memory handshakes. It sign- or zero-extends returned load data, detects misalignment, and times out lost read responses. It connects directly to the memory model or the memory subsystem ports of the same names.

## Interface
- TIMEOUT_CYCLES, 64: cycles in read-wait before an error response is forced; legal range 1..65535.
- TAG_W, 4: width of the request tag, which is echoed on the response.

- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1 / 1  core request handshake
- req_is_store  in  1  1 = store, 0 = load
- req_address  in  64  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_signed  in  1  for loads, sign-extend to 64 bits; ignored for stores
- req_data  in  64  store data, right-justified
- req_tag  in  TAG_W  opaque request id
- resp_valid / resp_ready  out / in  1 / 1  core response handshake
- resp_data  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  1 = misaligned access or read timeout
- resp_tag  out  TAG_W  tag of the completed request
- mem_dRead_addressInfo_valid / _ready  out / in  1 / 1  read address handshake
- mem_dRead_addressInfo_bits_address / _bits_size  out  64 / 2  read address and size
- mem_dRead_data_valid / _ready  in / out  1 / 1  read data handshake
- mem_dRead_data_bits  in  64  read data, right-justified
- mem_dWrite_storeInfo_valid / _ready  out / in  1 / 1  store handshake
- mem_dWrite_storeInfo_bits_addressInfo_address / _size  out  64 / 2  store address and size
- mem_dWrite_storeInfo_bits_data  out  64  store data, with bits above the size forced to 0

## Operation
- State machine states: IDLE, RD_ADDR, RD_WAIT, WR_REQ, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch address, size, signed, data and tag.
  - Misaligned request (address[size-1:0] ≠ 0, where size is 2,4 or 8 bytes) → RESP with err=1, data=0, and no memory access.
  - Aligned load → RD_ADDR. Aligned store → WR_REQ.
- RD_ADDR: addressInfo_valid=1 with the latched address and size. On _ready → RD_WAIT and clear the counter.
- RD_WAIT:
  - dRead_data_ready=1.
  - On data_valid, extend the data and go to RESP with err=0:
    - mask to 8·2^size bits;
    - if signed, replicate the top bit of that field upward, else zero-fill.
    - Size 3 passes the data through unchanged.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES-1 with no data → RESP with err=1, data=0.
- WR_REQ: storeInfo_valid=1 with the latched address, size and masked data. On _ready → RESP with err=0, data=0.
- RESP: resp_valid=1 with data, err and tag held stable until resp_ready → IDLE.
- Only one request is in flight. req_ready is 0 in every state except IDLE.
- Data is ignored outside RD_WAIT:
  - dRead_data_ready=0 in all other states;
  - a late data_valid after a timeout, or data_valid arriving in any other state, is dropped without a state change.
- Output valids depend only on state and latched registers, never combinationally on inputs.

## Timing
- Reset values: req_ready=0 during reset and 1 on the first cycle after it; every other output valid is 0; ready outputs are 0; data/address outputs are 0; state=IDLE; counter=0.
- Reset mid-transaction returns the block to IDLE on the next edge and abandons the pending memory operation.
- Minimum load latency, from req accept to resp_valid:
  - 1 cycle into RD_ADDR, then 1 cycle for an immediate addr_ready;
  - 1 cycle more for data_valid in the first RD_WAIT cycle;
  - total resp_valid 3 cycles after accept.
- Minimum store latency: resp_valid 2 cycles after accept. Misaligned requests: resp_valid 1 cycle after accept.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering RD_WAIT.
- If data_valid arrives in the same cycle the timeout would fire, the data wins and err=0.
- A back-to-back request can be accepted in the cycle after the resp handshake.

## Structure
- Package mem_if_pkg holds:
  - size constants SIZE_B/H/W/D;
  - the state enum;
  - a function size_mask(size) that returns the 64-bit mask;
  - a function misaligned(addr, size).
- Extension logic lives in the combinational sub-module load_data_extend (inputs data, size, signed; output 64-bit result). The same sub-module is reused by any later cache fill path.
- The counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Load, size=0, signed=1, at 0x1003; memory returns 0x…00F0 → resp_data=0xFFFF_FFFF_FFFF_FFF0, err=0, tag echoed, resp_valid 3 cycles after accept.
- Load, size=2, signed=0, memory returns 0xDEAD_BEEF_8000_0001 → resp_data=0x0000_0000_8000_0001.
- Store, size=1, data=0x1234_5678, addr 0x2002 → storeInfo shows data=0x5678 and size=1; resp err=0, data=0.
- Load, size=3, at 0x1004 → no dRead valid, resp err=1 one cycle after accept.
- TIMEOUT_CYCLES=8, memory never sends data → resp err=1 eight cycles after entering RD_WAIT. A data_valid injected later is ignored and the next request completes normally.
- addr_ready held low for 5 cycles with resp_ready held low, then reset asserted during RD_ADDR → all valids 0 the next cycle, and req_ready=1 after reset deasserts.
